// File: rtl/pid_output_processor.sv
// Turns signed per-channel PID results into saturated, deadbanded PWM duty/direction
// pairs with double-buffered period updates, a reversal dead period and a per-channel watchdog.
module pid_output_processor #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CHN     = 4,
    parameter int CHN_WIDTH   = 3,
    parameter int PWM_PERIOD  = 1024,
    parameter int DUTY_MAX    = 1023,
    parameter int DEADBAND    = 8,
    parameter int TIMEOUT_CYC = 216000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid_o,
    input  logic [CHN_WIDTH-1:0]  data_chn_o,
    input  logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  out_ready_o,
    output logic [NUM_CHN-1:0]    pwm_o,
    output logic [NUM_CHN-1:0]    dir_o,
    output logic [NUM_CHN-1:0]    timeout_o,
    output logic                  chn_err_o
);

    localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]      L_LAST       = CNT_W'(PWM_PERIOD - 1);
    localparam logic [CNT_W-1:0]      L_DUTY_MAX   = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0]      L_DEADBAND   = CNT_W'(DEADBAND);
    localparam logic [DATA_WIDTH:0]   L_DUTY_MAX_X = (DATA_WIDTH + 1)'(DUTY_MAX);
    localparam logic [WD_W-1:0]       L_TIMEOUT    = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]       L_TIMEOUT_M1 = WD_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0]      r_pwmCnt;
    logic                  r_s1Valid;
    logic [CHN_WIDTH-1:0]  r_s1Chn;
    logic [DATA_WIDTH-1:0] r_s1Data;
    logic                  r_chnErr;

    logic [CNT_W-1:0]      r_shadowDuty [NUM_CHN];
    logic [CNT_W-1:0]      r_activeDuty [NUM_CHN];
    logic [WD_W-1:0]       r_wdCnt      [NUM_CHN];
    logic [NUM_CHN-1:0]    r_shadowDir;
    logic [NUM_CHN-1:0]    r_activeDir;
    logic [NUM_CHN-1:0]    r_revPend;
    logic [NUM_CHN-1:0]    r_timeout;
    logic [NUM_CHN-1:0]    r_pwm;
    logic [NUM_CHN-1:0]    r_dir;

    logic                  w_transfer;
    logic                  w_inRange;
    logic                  w_neg;
    logic [DATA_WIDTH:0]   w_signedExt;
    logic [DATA_WIDTH:0]   w_abs;
    logic [CNT_W-1:0]      w_mag;
    logic                  w_inDeadband;
    logic [NUM_CHN-1:0]    w_wrHit;

    assign w_transfer  = (r_pwmCnt == L_LAST);
    assign out_ready_o = ~rst & ~w_transfer;

    // One extra bit keeps the most negative input representable after negation.
    assign w_inRange    = ({1'b0, r_s1Chn} < (CHN_WIDTH + 1)'(NUM_CHN));
    assign w_neg        = r_s1Data[DATA_WIDTH-1];
    assign w_signedExt  = {r_s1Data[DATA_WIDTH-1], r_s1Data};
    assign w_abs        = w_neg ? -w_signedExt : w_signedExt;
    assign w_mag        = (w_abs > L_DUTY_MAX_X) ? L_DUTY_MAX : w_abs[CNT_W-1:0];
    assign w_inDeadband = (w_mag < L_DEADBAND);

    always_comb begin
        w_wrHit = '0;
        for (int ch = 0; ch < NUM_CHN; ch++) begin
            w_wrHit[ch] = r_s1Valid && w_inRange && (r_s1Chn == CHN_WIDTH'(ch));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwmCnt  <= '0;
            r_s1Valid <= 1'b0;
            r_s1Chn   <= '0;
            r_s1Data  <= '0;
            r_chnErr  <= 1'b0;
        end else begin
            r_pwmCnt  <= w_transfer ? '0 : r_pwmCnt + CNT_W'(1);
            r_s1Valid <= data_valid_o && out_ready_o;
            if (data_valid_o && out_ready_o) begin
                r_s1Chn  <= data_chn_o;
                r_s1Data <= data_out_o;
            end
            r_chnErr  <= r_s1Valid && !w_inRange;
        end
    end

    // A stage-2 write outranks a same-cycle watchdog expiry; the transfer samples pre-edge shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CHN; ch++) begin
                r_shadowDuty[ch] <= '0;
                r_activeDuty[ch] <= '0;
                r_wdCnt[ch]      <= '0;
            end
            r_shadowDir <= '0;
            r_activeDir <= '0;
            r_revPend   <= '0;
            r_timeout   <= '0;
            r_pwm       <= '0;
            r_dir       <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHN; ch++) begin
                if (w_wrHit[ch]) begin
                    r_shadowDuty[ch] <= w_inDeadband ? '0 : w_mag;
                    if (!w_inDeadband) begin
                        r_shadowDir[ch] <= w_neg;
                    end
                    r_wdCnt[ch]   <= '0;
                    r_timeout[ch] <= 1'b0;
                end else if (r_wdCnt[ch] != L_TIMEOUT) begin
                    r_wdCnt[ch] <= r_wdCnt[ch] + WD_W'(1);
                    if (r_wdCnt[ch] == L_TIMEOUT_M1) begin
                        r_shadowDuty[ch] <= '0;
                        r_timeout[ch]    <= 1'b1;
                    end
                end

                if (w_transfer) begin
                    if (!r_revPend[ch] && (r_shadowDir[ch] != r_activeDir[ch]) &&
                        (r_activeDuty[ch] != '0)) begin
                        r_activeDuty[ch] <= '0;
                        r_revPend[ch]    <= 1'b1;
                    end else begin
                        r_activeDuty[ch] <= r_shadowDuty[ch];
                        r_activeDir[ch]  <= r_shadowDir[ch];
                        r_revPend[ch]    <= 1'b0;
                    end
                end

                r_pwm[ch] <= (r_pwmCnt < r_activeDuty[ch]);
                r_dir[ch] <= r_activeDir[ch];
            end
        end
    end

    assign pwm_o     = r_pwm;
    assign dir_o     = r_dir;
    assign timeout_o = r_timeout;
    assign chn_err_o = r_chnErr;

endmodule

// File: tb/tb_pid_output_processor.sv
// Self-checking bench for pid_output_processor: vector table, hand-written corner sequences
// and randomized traffic, all compared every cycle against a behavioural model.
module tb_pid_output_processor;

    localparam int DW     = 16;
    localparam int NCH    = 4;
    localparam int CW     = 3;
    localparam int PERIOD = 16;
    localparam int DMAX   = 12;
    localparam int DB     = 2;
    localparam int TMO    = 100;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            valid = 1'b0;
    logic [CW-1:0]   chn   = '0;
    logic [DW-1:0]   data  = '0;
    logic            ready;
    logic [NCH-1:0]  pwm;
    logic [NCH-1:0]  dir;
    logic [NCH-1:0]  tmo;
    logic            err;

    int checks    = 0;
    int errors    = 0;
    int tickCount = 0;

    typedef struct {
        int ch;
        int value;
        int expDuty;
        bit expDir;
    } vec_t;

    vec_t vecs[12];

    // Behavioural model state, updated once per rising edge.
    int mCnt;
    bit mPipeV;
    int mPipeChn;
    int mPipeData;
    int mShDuty  [NCH];
    int mActDuty [NCH];
    int mWd      [NCH];
    bit mShDir   [NCH];
    bit mActDir  [NCH];
    bit mRev     [NCH];
    bit mTmo     [NCH];
    bit mPwm     [NCH];
    bit mDirO    [NCH];
    bit mErr;

    pid_output_processor #(
        .DATA_WIDTH (DW),
        .NUM_CHN    (NCH),
        .CHN_WIDTH  (CW),
        .PWM_PERIOD (PERIOD),
        .DUTY_MAX   (DMAX),
        .DEADBAND   (DB),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_valid_o(valid),
        .data_chn_o  (chn),
        .data_out_o  (data),
        .out_ready_o (ready),
        .pwm_o       (pwm),
        .dir_o       (dir),
        .timeout_o   (tmo),
        .chn_err_o   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got still running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic void modelReset();
        mCnt = 0; mPipeV = 1'b0; mPipeChn = 0; mPipeData = 0; mErr = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            mShDuty[ch] = 0; mActDuty[ch] = 0; mWd[ch] = 0;
            mShDir[ch] = 1'b0; mActDir[ch] = 1'b0; mRev[ch] = 1'b0;
            mTmo[ch] = 1'b0; mPwm[ch] = 1'b0; mDirO[ch] = 1'b0;
        end
    endfunction

    function automatic void modelEdge(input bit r, input bit v, input int c, input int d);
        bit acc;
        bit neg;
        int mag;
        if (r) begin
            modelReset();
            return;
        end
        acc = v && (mCnt != PERIOD - 1);
        for (int ch = 0; ch < NCH; ch++) begin
            mPwm[ch]  = (mCnt < mActDuty[ch]);
            mDirO[ch] = mActDir[ch];
        end
        mErr = mPipeV && (mPipeChn >= NCH);
        if (mCnt == PERIOD - 1) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (!mRev[ch] && (mShDir[ch] != mActDir[ch]) && (mActDuty[ch] != 0)) begin
                    mActDuty[ch] = 0;
                    mRev[ch]     = 1'b1;
                end else begin
                    mActDuty[ch] = mShDuty[ch];
                    mActDir[ch]  = mShDir[ch];
                    mRev[ch]     = 1'b0;
                end
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (mPipeV && (mPipeChn == ch)) begin
                neg = (mPipeData < 0);
                mag = neg ? -mPipeData : mPipeData;
                if (mag > DMAX) mag = DMAX;
                if (mag < DB) begin
                    mShDuty[ch] = 0;
                end else begin
                    mShDuty[ch] = mag;
                    mShDir[ch]  = neg;
                end
                mWd[ch]  = 0;
                mTmo[ch] = 1'b0;
            end else if (mWd[ch] < TMO) begin
                mWd[ch]++;
                if (mWd[ch] == TMO) begin
                    mShDuty[ch] = 0;
                    mTmo[ch]    = 1'b1;
                end
            end
        end
        mCnt      = (mCnt + 1) % PERIOD;
        mPipeV    = acc;
        mPipeChn  = c;
        mPipeData = d;
    endfunction

    task automatic checkOutput(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [3*NCH+1:0] expVec;
        logic [3*NCH+1:0] actVec;
        @(posedge clk);
        modelEdge(rst, valid, int'(chn), int'($signed(data)));
        tickCount++;
        #1;
        expVec = '0;
        expVec[3*NCH+1] = !rst && (mCnt != PERIOD - 1);
        for (int ch = 0; ch < NCH; ch++) begin
            expVec[2*NCH+1+ch] = mPwm[ch];
            expVec[NCH+1+ch]   = mDirO[ch];
            expVec[1+ch]       = mTmo[ch];
        end
        expVec[0] = mErr;
        actVec = {ready, pwm, dir, tmo, err};
        checkOutput(actVec === expVec, $sformatf("cycle%0d outputs", tickCount),
                    int'(actVec), int'(expVec));
    endtask

    task automatic doReset();
        rst   = 1'b1;
        valid = 1'b0;
        tick();
        tick();
        checkOutput({ready, pwm, dir, tmo, err} === '0, "reset outputs",
                    int'({ready, pwm, dir, tmo, err}), 0);
        rst = 1'b0;
    endtask

    task automatic alignTo(input int target);
        int n = 0;
        while (mCnt != target && n < 2 * PERIOD) begin
            tick();
            n++;
        end
        if (mCnt != target) checkOutput(1'b0, "align bound", mCnt, target);
    endtask

    task automatic applyStimulus(input int ch, input int d);
        bit wasReady = 1'b0;
        int n = 0;
        valid = 1'b1;
        chn   = CW'(ch);
        data  = DW'(d);
        while (!wasReady && n < 4) begin
            wasReady = !rst && (mCnt != PERIOD - 1);
            tick();
            n++;
        end
        valid = 1'b0;
        if (!wasReady) checkOutput(1'b0, "accept bound", 0, 1);
    endtask

    // Caller aligns first so the window covers pwm_cnt 0..PERIOD-1 of one period.
    task automatic measurePeriod(input int ch, output int high, output bit d);
        high = pwm[ch] ? 1 : 0;
        for (int i = 1; i < PERIOD; i++) begin
            tick();
            if (pwm[ch]) high++;
        end
        d = dir[ch];
    endtask

    initial begin
        int  h;
        bit  d;
        int  t0;
        int  n;
        int  refused;
        int  pulses;
        int  pct;
        int  pctTable[5];

        vecs[0]  = '{0, 5, 5, 1'b0};
        vecs[1]  = '{1, -300, 12, 1'b1};
        vecs[2]  = '{1, 'h8000, 12, 1'b1};
        vecs[3]  = '{2, -6, 6, 1'b1};
        vecs[4]  = '{3, 12, 12, 1'b0};
        vecs[5]  = '{3, 13, 12, 1'b0};
        vecs[6]  = '{0, -1, 0, 1'b0};
        vecs[7]  = '{1, 1, 0, 1'b0};
        vecs[8]  = '{2, 2, 2, 1'b0};
        vecs[9]  = '{0, -2, 2, 1'b1};
        vecs[10] = '{3, 'h7FFF, 12, 1'b0};
        vecs[11] = '{2, -12, 12, 1'b1};
        pctTable = '{70, 3, 0, 40, 100};

        modelReset();
        doReset();

        for (int i = 0; i < 12; i++) begin
            doReset();
            alignTo(3);
            applyStimulus(vecs[i].ch, vecs[i].value);
            alignTo(1);
            measurePeriod(vecs[i].ch, h, d);
            checkOutput(h == vecs[i].expDuty, $sformatf("vec%0d duty", i), h, vecs[i].expDuty);
            checkOutput(d == vecs[i].expDir, $sformatf("vec%0d dir", i), int'(d), int'(vecs[i].expDir));
        end

        $display("[TB] reversal dead period on ch2");
        doReset();
        alignTo(3);
        applyStimulus(2, 6);
        alignTo(1);
        measurePeriod(2, h, d);
        checkOutput(h == 6 && d == 1'b0, "rev initial duty", h, 6);
        alignTo(3);
        applyStimulus(2, -6);
        alignTo(1);
        measurePeriod(2, h, d);
        checkOutput(h == 0, "rev dead duty", h, 0);
        checkOutput(d == 1'b0, "rev dead dir", int'(d), 0);
        alignTo(1);
        measurePeriod(2, h, d);
        checkOutput(h == 6, "rev new duty", h, 6);
        checkOutput(d == 1'b1, "rev new dir", int'(d), 1);

        $display("[TB] deadband and bad channel on ch3");
        doReset();
        alignTo(3);
        applyStimulus(3, 8);
        alignTo(1);
        measurePeriod(3, h, d);
        checkOutput(h == 8, "db pre duty", h, 8);
        alignTo(3);
        applyStimulus(3, 1);
        alignTo(1);
        measurePeriod(3, h, d);
        checkOutput(h == 0 && d == 1'b0, "db fwd duty", h, 0);
        alignTo(3);
        applyStimulus(5, 100);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (err) pulses++;
        end
        checkOutput(pulses == 1, "chn_err pulses", pulses, 1);
        alignTo(3);
        applyStimulus(3, -8);
        alignTo(1);
        measurePeriod(3, h, d);
        checkOutput(h == 8 && d == 1'b1, "db rev duty", h, 8);
        alignTo(3);
        applyStimulus(3, 1);
        alignTo(1);
        measurePeriod(3, h, d);
        checkOutput(h == 0, "db hold duty", h, 0);
        checkOutput(d == 1'b1, "db hold dir", int'(d), 1);

        $display("[TB] watchdog on ch0");
        doReset();
        alignTo(3);
        applyStimulus(0, 8);
        t0 = tickCount;
        alignTo(1);
        measurePeriod(0, h, d);
        checkOutput(h == 8, "wd pre duty", h, 8);
        n = 0;
        while (tmo[0] !== 1'b1 && n < 150) begin
            tick();
            n++;
        end
        checkOutput(tickCount - t0 == TMO + 1, "wd expiry delay", tickCount - t0, TMO + 1);
        checkOutput(tmo[1] === 1'b1, "wd idle ch1", int'(tmo[1]), 1);
        repeat (17) tick();
        alignTo(1);
        measurePeriod(0, h, d);
        checkOutput(h == 0, "wd expired duty", h, 0);
        alignTo(3);
        applyStimulus(0, 4);
        tick();
        checkOutput(tmo[0] === 1'b0, "wd cleared", int'(tmo[0]), 0);
        alignTo(1);
        measurePeriod(0, h, d);
        checkOutput(h == 4, "wd resumed duty", h, 4);

        $display("[TB] continuous valid and mid-period reset");
        doReset();
        valid   = 1'b1;
        chn     = '0;
        data    = DW'(9);
        refused = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (!ready) refused++;
        end
        checkOutput(refused == 2, "refusals per 32", refused, 2);
        alignTo(7);
        checkOutput(pwm[0] === 1'b1, "pre-reset pwm", int'(pwm[0]), 1);
        rst = 1'b1;
        tick();
        checkOutput({pwm, dir, tmo, err, ready} === '0, "mid reset outputs",
                    int'({pwm, dir, tmo, err, ready}), 0);
        rst = 1'b0;
        #1;
        checkOutput(ready === 1'b1, "ready after reset", int'(ready), 1);
        tick();
        valid = 1'b0;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            pct   = pctTable[i / 300];
            rst   = ($urandom_range(0, 399) == 0);
            valid = ($urandom_range(0, 99) < pct);
            chn   = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) data = DW'(int'($urandom_range(0, 30)) - 15);
            else                           data = DW'($urandom);
            tick();
        end
        rst   = 1'b0;
        valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
